// File: rtl/pool2d_stream.sv
// ---------------------------------------------------------------------------
// pool2d_stream
//
// Streaming 2x2 / stride-2 pooling engine. Conv outputs arrive one per
// valid/ready handshake in raster order. One pooled value is produced per
// 2x2 window as soon as its bottom-right pixel is accepted. Only half a row
// of partial (horizontal pair) results is buffered. Max or average pooling
// is selected per frame.
//
// Optional feature macro: POOL_RELU_EN
//   defined   -> every pooled result is clamped to 0 when negative
//   undefined -> results pass through signed and unmodified
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_mode       0 = max, 1 = average; latched on the first pixel of a frame
//   i_in_valid   input sample valid
//   o_in_ready   block can accept a sample this cycle
//   i_in_data    signed input sample (DATA_W)
//   o_out_valid  pooled result valid
//   i_out_ready  downstream accepts the result
//   o_out_data   signed pooled result (DATA_W)
//   o_out_addr   raster index of the result within the pooled map
//   o_out_last   marks the final result of a frame
//   o_busy       high from the first accepted pixel until the last result
//                of the frame has been accepted
// ---------------------------------------------------------------------------
module pool2d_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mode,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_out_last,
    output logic              o_busy
);

    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int P_W    = DATA_W + 1;
    localparam int LB_W   = DATA_W + 2;

    logic        [COL_W-1:0]  r_col;
    logic        [ROW_W-1:0]  r_row;
    logic                     r_mode;
    logic signed [DATA_W-1:0] r_pair;
    logic signed [LB_W-1:0]   r_line [HALF_W];
    logic                     r_out_valid;
    logic        [DATA_W-1:0] r_out_data;
    logic        [ADDR_W-1:0] r_out_addr;
    logic                     r_out_last;
    logic                     r_busy;

    logic                     w_accept;
    logic                     w_xfer;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_first;
    logic                     w_col_odd;
    logic                     w_row_odd;
    logic                     w_window_done;
    logic        [LB_AW-1:0]  w_lb_idx;
    logic signed [P_W-1:0]    w_pair_ext;
    logic signed [P_W-1:0]    w_pix_ext;
    logic signed [P_W-1:0]    w_pair_red;
    logic signed [LB_W-1:0]   w_p_lb;
    logic signed [LB_W-1:0]   w_lb_rd;
    logic signed [LB_W-1:0]   w_sum;
    logic signed [LB_W-1:0]   w_max;
    logic        [DATA_W-1:0] w_raw;
    logic        [DATA_W-1:0] w_result;

    // Single output register without skid buffer: a new sample may only be
    // taken when the output slot is empty or being drained this cycle.
    assign o_in_ready    = !r_out_valid || i_out_ready;
    assign w_accept      = i_in_valid && o_in_ready;
    assign w_xfer        = r_out_valid && i_out_ready;

    assign w_col_last    = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last    = (r_row == ROW_W'(IMG_H - 1));
    assign w_first       = (r_col == '0) && (r_row == '0);
    assign w_col_odd     = r_col[0];
    assign w_row_odd     = r_row[0];
    assign w_window_done = w_accept && w_col_odd && w_row_odd;
    assign w_lb_idx      = LB_AW'(r_col >> 1);

    // Horizontal pair reduction; one extra bit keeps the avg-mode sum exact.
    assign w_pair_ext = {r_pair[DATA_W-1], r_pair};
    assign w_pix_ext  = {i_in_data[DATA_W-1], i_in_data};
    assign w_pair_red = r_mode ? (w_pair_ext + w_pix_ext)
                               : ((w_pix_ext > w_pair_ext) ? w_pix_ext : w_pair_ext);
    assign w_p_lb     = {w_pair_red[P_W-1], w_pair_red};

    // Vertical combine with the pair stored from the row above.
    assign w_lb_rd = r_line[w_lb_idx];
    assign w_sum   = w_lb_rd + w_p_lb;
    assign w_max   = (w_p_lb > w_lb_rd) ? w_p_lb : w_lb_rd;
    assign w_raw   = r_mode ? DATA_W'(w_sum >>> 2) : DATA_W'(w_max);

`ifdef POOL_RELU_EN
    assign w_result = w_raw[DATA_W-1] ? '0 : w_raw;
`else
    assign w_result = w_raw;
`endif

    // Raster position, per-frame mode latch and horizontal pair register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= 1'b0;
            r_pair <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_mode <= i_mode;
            end
            if (!w_col_odd) begin
                r_pair <= i_in_data;
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Half-row buffer of pair results from even rows; contents need no reset
    // because every entry is rewritten before the odd row reads it.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_accept && w_col_odd && !w_row_odd) begin
            r_line[w_lb_idx] <= w_p_lb;
        end
    end

    // Output register, transfer-counted address and frame busy flag.
    // A window completion always coincides with an empty or draining slot,
    // so loading takes precedence over clearing out_valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_window_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_out_last  <= w_col_last && w_row_last;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_xfer) begin
                r_out_addr <= r_out_last ? '0 : r_out_addr + 1'b1;
            end

            // A new frame starting in the same cycle as the last transfer
            // keeps busy high across the boundary.
            if (w_accept && w_first) begin
                r_busy <= 1'b1;
            end else if (w_xfer && r_out_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_out_last  = r_out_last;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_pool2d_stream.sv
// ---------------------------------------------------------------------------
// tb_pool2d_stream
//
// Self-checking bench for pool2d_stream. A 4x4 instance carries most of the
// traffic and a 2x2 instance covers the smallest map. Expected results are
// computed from the pixel frame by a small reference model and queued as the
// window-completing pixel is driven; monitors pop and compare on transfer.
// ---------------------------------------------------------------------------
module tb_pool2d_stream;

    typedef struct {
        int data;
        int addr;
        bit last;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        v4, rdy4, v2, rdy2;
    logic [15:0] d4, d2;
    logic        ir4, ov4, ol4, ob4;
    logic        ir2, ov2, ol2, ob2;
    logic [15:0] od4, od2;
    logic [7:0]  oa4, oa2;

    expT q4[$];
    expT q2[$];
    int  addrCnt[2];
    int  framePix[16];
    int  nCompared   = 0;
    int  nMismatched = 0;

    always #5 clk = ~clk;

    pool2d_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .ADDR_W(8)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode),
        .i_in_valid(v4), .o_in_ready(ir4), .i_in_data(d4),
        .o_out_valid(ov4), .i_out_ready(rdy4), .o_out_data(od4),
        .o_out_addr(oa4), .o_out_last(ol4), .o_busy(ob4)
    );

    pool2d_stream #(.DATA_W(16), .IMG_W(2), .IMG_H(2), .ADDR_W(8)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode),
        .i_in_valid(v2), .o_in_ready(ir2), .i_in_data(d2),
        .o_out_valid(ov2), .i_out_ready(rdy2), .o_out_data(od2),
        .o_out_addr(oa2), .o_out_last(ol2), .o_busy(ob2)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nCompared++;
        if (observed != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference pooling of window (wr,wc) straight from the pixel frame.
    function automatic int windowResult(input int sel, input int wr, input int wc, input logic m);
        int w = (sel != 0) ? 2 : 4;
        int a = framePix[(2*wr)*w + 2*wc];
        int b = framePix[(2*wr)*w + 2*wc + 1];
        int c = framePix[(2*wr+1)*w + 2*wc];
        int d = framePix[(2*wr+1)*w + 2*wc + 1];
        int res;
        if (m) begin
            res = (a + b + c + d) >>> 2;
        end else begin
            res = a;
            if (b > res) res = b;
            if (c > res) res = c;
            if (d > res) res = d;
        end
`ifdef POOL_RELU_EN
        if (res < 0) res = 0;
`endif
        return res;
    endfunction

    function automatic bit dutReady(input int sel);
        return (sel != 0) ? ir2 : ir4;
    endfunction

    task automatic applyStimulus(input int sel, input int pix, input logic m);
        int guard = 0;
        mode = m;
        if (sel == 0) begin v4 = 1'b1; d4 = 16'(pix); end
        else          begin v2 = 1'b1; d2 = 16'(pix); end
        @(negedge clk);
        while (!dutReady(sel) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (sel == 0) v4 = 1'b0;
        else          v2 = 1'b0;
    endtask

    task automatic runFrame(input int sel, input logic m, input int toggleAt, input int nPix);
        int w = (sel != 0) ? 2 : 4;
        for (int i = 0; i < nPix; i++) begin
            int   r = i / w;
            int   c = i % w;
            logic mm;
            bit   done;
            expT  e;
            mm   = (toggleAt >= 0 && i >= toggleAt) ? ~m : m;
            done = (r % 2 == 1) && (c % 2 == 1);
            if (done) begin
                e.data = windowResult(sel, r / 2, c / 2, m);
                e.addr = addrCnt[sel];
                e.last = (i == w * w - 1);
                addrCnt[sel] = e.last ? 0 : addrCnt[sel] + 1;
                if (sel == 0) q4.push_back(e);
                else          q2.push_back(e);
            end
            applyStimulus(sel, framePix[i], mm);
            if (done) checkOutput("lat_valid", int'((sel != 0) ? ov2 : ov4), 1);
            checkOutput("busy_in_frame", int'((sel != 0) ? ob2 : ob4), 1);
        end
    endtask

    // Holds the 4x4 output stalled for several cycles once a result appears.
    task automatic stallOutput();
        int g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while (!ov4 && g < 100);
        if (!ov4) begin
            checkOutput("bp_valid_timeout", 0, 1);
        end else begin
            rdy4 = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                checkOutput("bp_in_ready", int'(ir4), 0);
                checkOutput("bp_data_hold", $signed(od4), q4[0].data);
                checkOutput("bp_addr_hold", int'(oa4), q4[0].addr);
            end
            @(posedge clk);
            #1;
            rdy4 = 1'b1;
        end
    endtask

    always @(negedge clk) begin : mon4
        expT e;
        if (rst_n && ov4 && rdy4) begin
            if (q4.size() == 0) begin
                checkOutput("unexpected_out4", 1, 0);
            end else begin
                e = q4.pop_front();
                checkOutput("data4", $signed(od4), e.data);
                checkOutput("addr4", int'(oa4), e.addr);
                checkOutput("last4", int'(ol4), int'(e.last));
            end
        end
    end

    always @(negedge clk) begin : mon2
        expT e;
        if (rst_n && ov2 && rdy2) begin
            if (q2.size() == 0) begin
                checkOutput("unexpected_out2", 1, 0);
            end else begin
                e = q2.pop_front();
                checkOutput("data2", $signed(od2), e.data);
                checkOutput("addr2", int'(oa2), e.addr);
                checkOutput("last2", int'(ol2), int'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        rst_n = 1'b0; mode = 1'b0;
        v4 = 1'b0; v2 = 1'b0; d4 = '0; d2 = '0;
        rdy4 = 1'b1; rdy2 = 1'b1;
        addrCnt[0] = 0; addrCnt[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", int'(ov4), 0);
        checkOutput("rst_data", int'(od4), 0);
        checkOutput("rst_addr", int'(oa4), 0);
        checkOutput("rst_last", int'(ol4), 0);
        checkOutput("rst_busy", int'(ob4), 0);
        checkOutput("rst_in_ready", int'(ir4), 1);
        checkOutput("rst_valid2", int'(ov2), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] ramp frame, max then avg");
        for (int i = 0; i < 16; i++) framePix[i] = i;
        runFrame(0, 1'b0, -1, 16);
        runFrame(0, 1'b1, -1, 16);

        $display("[TB] 2x2 negative frame, max then avg");
        framePix[0] = -3; framePix[1] = -1; framePix[2] = -8; framePix[3] = -2;
        runFrame(1, 1'b0, -1, 4);
        runFrame(1, 1'b1, -1, 4);

        $display("[TB] backpressure on random frame");
        for (int i = 0; i < 16; i++) framePix[i] = int'($signed(16'($urandom)));
        fork
            runFrame(0, 1'b0, -1, 16);
            stallOutput();
        join

        $display("[TB] back-to-back frames with mid-frame mode change");
        for (int i = 0; i < 16; i++) framePix[i] = int'($signed(16'($urandom)));
        runFrame(0, 1'b0, 6, 16);
        runFrame(0, 1'b1, -1, 16);

        $display("[TB] extreme values");
        for (int i = 0; i < 16; i++) framePix[i] = 0;
        framePix[0]  = 32767;  framePix[1]  = 32767;  framePix[4]  = 32767;  framePix[5]  = 32767;
        framePix[2]  = -32768; framePix[3]  = -32768; framePix[6]  = -32768; framePix[7]  = -32768;
        framePix[8]  = 32767;  framePix[9]  = -32768; framePix[12] = -32768; framePix[13] = 32767;
        framePix[10] = -1;     framePix[11] = 0;      framePix[14] = -1;     framePix[15] = -2;
        runFrame(0, 1'b1, -1, 16);
        runFrame(0, 1'b0, -1, 16);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 16; i++) framePix[i] = int'($signed(16'($urandom)));
        runFrame(0, 1'b0, -1, 9);
        g = 0;
        while (q4.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        checkOutput("pre_reset_drain", q4.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_valid", int'(ov4), 0);
        checkOutput("midrst_busy", int'(ob4), 0);
        rst_n = 1'b1;
        addrCnt[0] = 0;
        addrCnt[1] = 0;
        for (int i = 0; i < 16; i++) framePix[i] = int'($signed(16'($urandom)));
        runFrame(0, 1'b1, -1, 16);

        g = 0;
        while ((q4.size() != 0 || q2.size() != 0) && g < 50) begin
            @(negedge clk);
            g++;
        end
        checkOutput("q4_left", q4.size(), 0);
        checkOutput("q2_left", q2.size(), 0);
        @(posedge clk);
        #1;
        checkOutput("idle_busy4", int'(ob4), 0);
        checkOutput("idle_busy2", int'(ob2), 0);
        checkOutput("idle_valid4", int'(ov4), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
